// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state enum,
// base byte-lane masks and a funct3 validity helper.
// No ports; imported by lsu and lsu_align.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the LSU: byte-offset/funct3 to an 8-bit
// two-word byte mask, 64-bit lane-shifted store data, extended load data and
// a misalignment flag. Ports: off_i, funct3_i, wdata_i, rd0_i, rd1_i in;
// mask_o, wdata_o, rdata_o, misalign_o out.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rd0_i,
    input  logic [31:0] rd1_i,
    output logic [7:0]  mask_o,
    output logic [63:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [3:0]  base;
    logic [31:0] rd_sh;

    always_comb begin
        base = 4'b0000;
        case (funct3_i)
            F3_B, F3_BU: base = MASK_B;
            F3_H, F3_HU: base = MASK_H;
            F3_W:        base = MASK_W;
            default:     base = 4'b0000;
        endcase

        // Bits [3:0] address the first word, [7:4] the following word.
        mask_o  = {4'b0000, base} << off_i;
        wdata_o = {32'h0, wdata_i} << {off_i, 3'b000};

        rd_sh = 32'({rd1_i, rd0_i} >> {off_i, 3'b000});
        case (funct3_i)
            F3_B:    rdata_o = {{24{rd_sh[7]}}, rd_sh[7:0]};
            F3_BU:   rdata_o = {24'h0, rd_sh[7:0]};
            F3_H:    rdata_o = {{16{rd_sh[15]}}, rd_sh[15:0]};
            F3_HU:   rdata_o = {16'h0, rd_sh[15:0]};
            F3_W:    rdata_o = rd_sh;
            default: rdata_o = 32'h0;
        endcase

        misalign_o = (((funct3_i == F3_H) || (funct3_i == F3_HU)) && (off_i == 2'd3)) ||
                     ((funct3_i == F3_W) && (off_i != 2'd0));
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one byte-addressed request at a time mapped onto a
// word-addressed memory. Ports: request (i_req/o_ready, i_we, i_funct3,
// i_addr, i_wdata), response (o_rsp_valid, o_rdata, o_err), memory
// (o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren, i_mem_rdata).
// Optional feature macro LSU_MISALIGN_SPLIT_EN: misaligned half/word accesses
// run as two memory cycles instead of returning an error.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req,
    output logic              o_ready,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rdata,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1;

    logic [1:0]        off_sel;
    logic [2:0]        f3_sel;
    logic [7:0]        mask8;
    logic [63:0]       wdata64;
    logic [31:0]       rdata_ext;
    logic              misalign;
    logic [ADDR_W-1:0] word0, word1;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0] rd1_q, rd1_d;
    assign rd1 = rd1_q;
`else
    // Second word is never accessed in this build.
    logic unused_split;
    assign rd1          = 32'h0;
    assign unused_split = ^{mask8[7:4], wdata64[63:32]};
`endif

    // In IDLE the aligner looks at the live request so the error decision can
    // be made at acceptance; elsewhere it only sees the latched request.
    assign off_sel = (state_q == IDLE) ? i_addr[1:0] : addr_q[1:0];
    assign f3_sel  = (state_q == IDLE) ? i_funct3    : f3_q;

    lsu_align u_align (
        .off_i      (off_sel),
        .funct3_i   (f3_sel),
        .wdata_i    (wdata_q),
        .rd0_i      (rd0_q),
        .rd1_i      (rd1),
        .mask_o     (mask8),
        .wdata_o    (wdata64),
        .rdata_o    (rdata_ext),
        .misalign_o (misalign)
    );

    generate
        if (ADDR_W > 30) begin : g_wide
            assign word0 = {{(ADDR_W-30){1'b0}}, addr_q[31:2]};
        end else begin : g_narrow
            assign word0 = addr_q[ADDR_W+1:2];
        end
    endgenerate
    assign word1 = word0 + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rd0_d       = rd0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        rd1_d       = rd1_q;
`endif
        o_ready     = 1'b0;
        o_rsp_valid = 1'b0;
        o_rdata     = 32'h0;
        o_err       = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = 32'h0;
        o_mem_bmask = 4'b0000;
        o_mem_wren  = 1'b0;

        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_req) begin
                    addr_d  = i_addr;
                    f3_d    = i_funct3;
                    we_d    = i_we;
                    wdata_d = i_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
                    err_d   = !f3_valid(i_funct3);
`else
                    err_d   = !f3_valid(i_funct3) || misalign;
`endif
                    state_d = err_d ? RESP : ACC0;
                end
            end
            ACC0: begin
                o_mem_addr  = word0;
                o_mem_bmask = mask8[3:0];
                o_mem_wdata = wdata64[31:0];
                o_mem_wren  = we_q;
                rd0_d       = i_mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
                state_d     = (|mask8[7:4]) ? ACC1 : RESP;
`else
                state_d     = RESP;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1: begin
                o_mem_addr  = word1;
                o_mem_bmask = mask8[7:4];
                o_mem_wdata = wdata64[63:32];
                o_mem_wren  = we_q;
                rd1_d       = i_mem_rdata;
                state_d     = RESP;
            end
`endif
            RESP: begin
                o_rsp_valid = 1'b1;
                o_err       = err_q;
                o_rdata     = (we_q || err_q) ? 32'h0 : rdata_ext;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef LSU_MISALIGN_SPLIT_EN
    // word1 only feeds the second access, absent here.
    logic unused_word1;
    assign unused_word1 = ^word1;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rd0_q   <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
            rd1_q   <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rd0_q   <= rd0_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            rd1_q   <= rd1_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_req;
    logic        o_ready;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rdata;
    logic        o_err;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    lsu #(.ADDR_W(32)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_req       (i_req),
        .o_ready     (o_ready),
        .i_we        (i_we),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_bmask (o_mem_bmask),
        .o_mem_wren  (o_mem_wren),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Memory attached to the DUT (16 words, index wraps).
    logic [31:0] mem [16];
    int          wren_cnt = 0;
    assign i_mem_rdata = mem[o_mem_addr[3:0]];
    always @(posedge i_clk) begin
        if (o_mem_wren) begin
            wren_cnt++;
            for (int b = 0; b < 4; b++)
                if (o_mem_bmask[b]) mem[o_mem_addr[3:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
        end
    end

    // Reference memory as a flat byte array (64 bytes, little endian).
    logic [7:0] ref_b [64];

    int n_vec = 0;
    int n_bad = 0;

    // Memory accesses seen during the last request.
    int          acc_n;
    logic [31:0] acc_addr  [4];
    logic [3:0]  acc_mask  [4];
    logic [31:0] acc_wdata [4];
    logic        acc_wren  [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mem_set(input int idx, input logic [31:0] w);
        mem[idx] = w;
        for (int b = 0; b < 4; b++) ref_b[idx*4 + b] = w[8*b +: 8];
    endtask

    task automatic mem_clear();
        for (int i = 0; i < 16; i++) mem_set(i, 32'h0);
    endtask

    // Behavioural model: expected response straight from the access rules.
    task automatic ref_calc(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            output logic [31:0] rd, output logic err, output int lat);
        int   size, off, a;
        logic valid, mis;
        logic [31:0] v;
        valid = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr[1:0]);
        a     = int'(addr[5:0]);
        mis   = (size == 2 && off == 3) || (size == 4 && off != 0);
        err   = !valid || (mis && !SPLIT);
        lat   = err ? 1 : ((off + size > 4) ? 3 : 2);
        v = 32'h0;
        for (int k = 0; k < size; k++) v[8*k +: 8] = ref_b[(a + k) % 64];
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        rd = (err || we) ? 32'h0 : v;
    endtask

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int size, a;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a    = int'(addr[5:0]);
        for (int k = 0; k < size; k++) ref_b[(a + k) % 64] = wd[8*k +: 8];
    endtask

    // Issue one request from a negedge with the DUT idle; returns the response
    // and its latency in cycles after the accepting edge (-1 on timeout).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat);
        logic [31:0] m_rd;
        logic        m_err;
        int          m_lat;
        bit          got;
        ref_calc(we, f3, addr, m_rd, m_err, m_lat);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        @(posedge i_clk);
        #1 i_req = 1'b0;
        acc_n = 0; got = 1'b0; lat = -1; rd = 32'hx; err = 1'bx;
        for (int k = 1; k <= 6 && !got; k++) begin
            @(negedge i_clk);
            if (o_mem_bmask != 4'b0000 && acc_n < 4) begin
                acc_addr[acc_n]  = o_mem_addr;
                acc_mask[acc_n]  = o_mem_bmask;
                acc_wdata[acc_n] = o_mem_wdata;
                acc_wren[acc_n]  = o_mem_wren;
                acc_n++;
            end
            if (o_rsp_valid) begin
                got = 1'b1; lat = k; rd = o_rdata; err = o_err;
            end
        end
        @(negedge i_clk);
        if (we && !m_err) ref_store(f3, addr, wd);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [31:0] rd, e_rd;
        logic        er, e_er;
        int          lat, e_lat, w0;
        bit          rsp_seen;

        i_reset_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b0;
        i_addr = 32'h0; i_wdata = 32'h0;
        mem_clear();
        mem_set(0, 32'h8899AABB);
        mem_set(1, 32'h55667788);
        repeat (2) @(negedge i_clk);
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_rsp",   {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_err",   {31'b0, o_err}, 32'd0);
        chk("rst_maddr", o_mem_addr, 32'h0);
        chk("rst_mwd",   o_mem_wdata, 32'h0);
        chk("rst_mmask", {28'b0, o_mem_bmask}, 32'd0);
        chk("rst_mwren", {31'b0, o_mem_wren}, 32'd0);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // SH 0x1234 at byte 6 lands in the upper half of word 1.
        do_req(1'b1, 3'b001, 32'd6, 32'h00001234, rd, er, lat);
        chk("sh_lat",   32'(lat), 32'd2);
        chk("sh_nacc",  32'(acc_n), 32'd1);
        chk("sh_addr",  acc_addr[0], 32'd1);
        chk("sh_mask",  {28'b0, acc_mask[0]}, 32'hC);
        chk("sh_wdata", acc_wdata[0], 32'h12340000);
        chk("sh_wren",  {31'b0, acc_wren[0]}, 32'd1);

        vt[0]  = '{1'b0, 3'b000, 32'd3, 32'h0, 32'hFFFFFF88, 1'b0, 2};
        vt[1]  = '{1'b0, 3'b100, 32'd3, 32'h0, 32'h00000088, 1'b0, 2};
        vt[2]  = '{1'b0, 3'b001, 32'd0, 32'h0, 32'hFFFFAABB, 1'b0, 2};
        vt[3]  = '{1'b0, 3'b101, 32'd2, 32'h0, 32'h00008899, 1'b0, 2};
        vt[4]  = '{1'b0, 3'b010, 32'd0, 32'h0, 32'h8899AABB, 1'b0, 2};
        vt[5]  = '{1'b0, 3'b010, 32'd4, 32'h0, 32'h12347788, 1'b0, 2};
        vt[6]  = '{1'b0, 3'b011, 32'd0, 32'h0, 32'h0, 1'b1, 1};
        vt[7]  = '{1'b1, 3'b111, 32'd8, 32'hFFFFFFFF, 32'h0, 1'b1, 1};
        if (SPLIT) vt[8] = '{1'b0, 3'b001, 32'd3, 32'h0, 32'hFFFF8888, 1'b0, 3};
        else       vt[8] = '{1'b0, 3'b001, 32'd3, 32'h0, 32'h0, 1'b1, 1};
        vt[9]  = '{1'b1, 3'b000, 32'd1, 32'h000000A5, 32'h0, 1'b0, 2};
        vt[10] = '{1'b0, 3'b100, 32'd1, 32'h0, 32'h000000A5, 1'b0, 2};

        for (int i = 0; i < 11; i++) begin
            w0 = wren_cnt;
            do_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vt[i].exp_err});
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
            if (vt[i].exp_err) chk($sformatf("vec%0d_nowren", i), 32'(wren_cnt - w0), 32'd0);
        end

        // LW at byte 2 across words 0/1.
        mem_set(0, 32'h44332211);
        mem_set(1, 32'h88776655);
        w0 = wren_cnt;
        do_req(1'b0, 3'b010, 32'd2, 32'h0, rd, er, lat);
        if (SPLIT) begin
            chk("lw2_rdata", rd, 32'h66554433);
            chk("lw2_lat",   32'(lat), 32'd3);
            chk("lw2_nacc",  32'(acc_n), 32'd2);
            chk("lw2_addr0", acc_addr[0], 32'd0);
            chk("lw2_addr1", acc_addr[1], 32'd1);
            chk("lw2_mask0", {28'b0, acc_mask[0]}, 32'hC);
            chk("lw2_mask1", {28'b0, acc_mask[1]}, 32'h3);
        end else begin
            chk("lw2_rdata", rd, 32'h0);
            chk("lw2_err",   {31'b0, er}, 32'd1);
            chk("lw2_lat",   32'(lat), 32'd1);
            chk("lw2_nacc",  32'(acc_n), 32'd0);
            chk("lw2_nowren", 32'(wren_cnt - w0), 32'd0);
        end

        // SW 0xDEADBEEF at byte 3.
        w0 = wren_cnt;
        do_req(1'b1, 3'b010, 32'd3, 32'hDEADBEEF, rd, er, lat);
        if (SPLIT) begin
            chk("sw3_err",  {31'b0, er}, 32'd0);
            chk("sw3_nacc", 32'(acc_n), 32'd2);
            chk("sw3_mask0", {28'b0, acc_mask[0]}, 32'h8);
            chk("sw3_wd0",  acc_wdata[0], 32'hEF000000);
            chk("sw3_mask1", {28'b0, acc_mask[1]}, 32'h7);
            chk("sw3_wd1",  acc_wdata[1], 32'h00DEADBE);
            chk("sw3_addr1", acc_addr[1], 32'd1);
            chk("sw3_mem0", mem[0], 32'hEF332211);
            chk("sw3_mem1", mem[1], 32'h88DEADBE);
        end else begin
            chk("sw3_err",  {31'b0, er}, 32'd1);
            chk("sw3_lat",  32'(lat), 32'd1);
            chk("sw3_nowren", 32'(wren_cnt - w0), 32'd0);
        end

        // Reset during the last memory cycle of a store.
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010;
        i_addr = SPLIT ? 32'd3 : 32'd0; i_wdata = 32'hCAFEF00D;
        @(posedge i_clk);
        #1 i_req = 1'b0;
        repeat (SPLIT ? 2 : 1) @(negedge i_clk);
        chk("rmid_wren_before", {31'b0, o_mem_wren}, 32'd1);
        i_reset_n = 1'b0;
        #1;
        chk("rmid_wren_after", {31'b0, o_mem_wren}, 32'd0);
        rsp_seen = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_rsp_valid) rsp_seen = 1'b1;
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
        if (o_rsp_valid) rsp_seen = 1'b1;
        chk("rmid_no_rsp", {31'b0, rsp_seen}, 32'd0);
        chk("rmid_ready",  {31'b0, o_ready}, 32'd1);

        // Randomized traffic against the byte-level model.
        mem_clear();
        for (int i = 0; i < 16; i++) mem_set(i, $urandom);
        for (int i = 0; i < 300; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr, wd;
            int          r;
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (we) f3 = (r < 8) ? 3'(r % 3) : ((r == 8) ? 3'b011 : 3'b110);
            else    f3 = (r < 8) ? ((r % 5 < 3) ? 3'(r % 5) : 3'(r % 5 + 1)) : 3'b111;
            addr = 32'($urandom_range(0, 63));
            wd   = $urandom;
            ref_calc(we, f3, addr, e_rd, e_er, e_lat);
            do_req(we, f3, addr, wd, rd, er, lat);
            chk($sformatf("rnd%0d_rdata", i), rd, e_rd);
            chk($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, e_er});
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(e_lat));
        end
        for (int i = 0; i < 16; i++)
            chk($sformatf("mem%0d", i), mem[i],
                {ref_b[i*4+3], ref_b[i*4+2], ref_b[i*4+1], ref_b[i*4]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit placed between the core's execute stage and the word-addressed data `memory`. It accepts one byte-addressed RV32I load/store request at a time, converts it to word-index addresses, byte masks and lane-shifted write data, and sign- or zero-extends the returned read data. Accesses that cross a word boundary are split into two memory cycles when split support is compiled in.

## Interface
- `ADDR_W`, default 32: width of the word-index address driven to memory.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: request valid.
- `o_ready` out 1: request accepted when `i_req && o_ready`.
- `i_we` in 1: 1 = store, 0 = load.
- `i_funct3` in 3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; all other codes are invalid.
- `i_addr` in 32: byte address.
- `i_wdata` in 32: store data, right-aligned.
- `o_rsp_valid` out 1: one-cycle response pulse.
- `o_rdata` out 32: extended load data, valid with `o_rsp_valid`; 0 for stores and errors.
- `o_err` out 1: misaligned or invalid request, valid with `o_rsp_valid`.
- `o_mem_addr` out ADDR_W: word index, `byte_addr[ADDR_W+1:2]`.
- `o_mem_wdata` out 32: lane-shifted store data.
- `o_mem_bmask` out 4: byte enables.
- `o_mem_wren` out 1: write enable.
- `i_mem_rdata` in 32: combinational read word for `o_mem_addr`.

## Operation
- The request is latched at acceptance: addr, funct3, we, wdata. Offset `off = addr[1:0]`.
- Base mask: byte `0001`, half `0011`, word `1111`. The 8-bit mask is `base << off`. Bits [3:0] go to word 0 and bits [7:4] go to word 1.
- Write data: 64-bit `{32'b0, wdata} << (8*off)`. The low half goes to word 0 and the high half to word 1.
- Read data: `{rd1, rd0} >> (8*off)`, then bits [7:0] or [15:0] are sign- or zero-extended according to funct3. For LW the full 32 bits are used.
- An access is misaligned when it is a half with `off==3` or a word with `off!=0`. An access spans when the 8-bit mask has any bit in [7:4] set.
- FSM states: IDLE, ACC0, ACC1, RESP.
  - IDLE: `o_ready=1`. On accept: go to RESP with `err=1` if funct3 is invalid or the access is misaligned and not splittable; otherwise go to ACC0.
  - ACC0: drive word `addr>>2`, `o_mem_bmask` = low mask, `o_mem_wren = we`. Capture `rd0 <= i_mem_rdata`. Go to ACC1 if the access spans, else RESP.
  - ACC1: drive word `(addr>>2)+1` (wraps modulo 2^ADDR_W), `o_mem_bmask` = high mask, `o_mem_wren = we`. Capture `rd1`. Go to RESP.
  - RESP: `o_rsp_valid=1`, `o_rdata`/`o_err` from registers. Go to IDLE. There is no response backpressure.
- In IDLE and RESP, memory outputs are all 0 (`addr`, `wdata`, `bmask`, `wren`). Memory outputs are decoded from state and latched request, not from live inputs.
- An error never asserts `o_mem_wren`.

## Timing
- Accept at edge N.
  - Aligned access: ACC0 during cycle N+1, `o_rsp_valid` during cycle N+2.
  - Split access: `o_rsp_valid` during cycle N+3.
  - Error: `o_rsp_valid` during cycle N+1.
- Next accept is possible in the cycle following RESP. Throughput is one request per 3 cycles aligned, 4 cycles split.
- The store write commits at the clock edge ending ACC0 (and ACC1 for splits).
- Reset values: state IDLE, `o_ready=1`, `o_rsp_valid=0`, `o_rdata=0`, `o_err=0`, all memory outputs 0.
- Reset asserted mid-operation returns to IDLE immediately and no response is issued. For a split store interrupted after ACC0, word 0 stays written; this is accepted behaviour.
- `i_req` while not ready is ignored. It is not queued.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: misaligned half/word accesses run as ACC0→ACC1 two-word transactions with `o_err=0`.
- Not defined: ACC1 is unreachable and is removed. Misaligned accesses return `o_err=1`, `o_rdata=0`, with no memory access.

## Structure
- `lsu_pkg` contains:
  - `funct3` constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State enum `lsu_state_e`.
  - Mask constants.
- Sub-module `lsu_align` is purely combinational: off, funct3, wdata, rd0, rd1 → 8-bit mask, 64-bit shifted wdata, extended rdata, misaligned flag.
- `lsu` holds the FSM and the request/read-data registers.

## Test plan
- Reset with memory word 0 = `0x8899AABB`, LB at addr 3: rsp at N+2, `o_rdata=0xFFFFFF88`, `o_err=0`. Also check LBU at addr 3 → `0x00000088`.
- SH `0x1234` at addr 6: ACC0 on word 1 with `bmask=1100`, `wdata=0x12340000`. A following LW at addr 4 returns `0x1234xxxx` with the low half unchanged.
- With split enabled, word 0 = `0x44332211` and word 1 = `0x88776655`, LW at addr 2: words 0 then 1 are accessed, `o_rdata=0x66554433`, rsp at N+3.
- With split enabled, SW `0xDEADBEEF` at addr 3: word 0 `bmask=1000`, `wdata=0xEF000000`; word 1 `bmask=0111`, `wdata=0x00DEADBE`.
- With split disabled, LH at addr 3: `o_err=1`, `o_rdata=0`, rsp at N+1, `o_mem_wren` never asserted. With either config, invalid funct3 `011` gives the same result.
- Split SW in flight: assert `i_reset_n=0` during ACC1 → `o_mem_wren` drops immediately, no `o_rsp_valid`, `o_ready=1` after reset is released.
